serial_cmd_frame_parser: RTL and testbench

//   Parametrised ASCII command-frame parser between the UART receiver and the control datapath (PWM, limits).

---
 rtl/serial_cmd_frame_parser_pkg.sv | 17 +
 rtl/serial_cmd_frame_parser_ascii_digit_accumulator.sv | 40 ++++
 rtl/serial_cmd_frame_parser.sv | 121 ++++++++++++
 tb/tb_serial_cmd_frame_parser.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmd_frame_parser_pkg.sv
// Shared ASCII constants, parser state encodings and a digit classifier,
// reused by the UART receiver and the other command parsers.
package serial_cmd_frame_parser_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FIELD = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/serial_cmd_frame_parser_ascii_digit_accumulator.sv
// Decimal accumulator for one fixed-width field. value is the running total
// including the digit being presented; it self-clears after the last digit.
module ascii_digit_accumulator #(
    parameter int DIGITS  = 2,
    parameter int FIELD_W = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               digit_valid,
    input  logic [3:0]         digit,
    output logic [FIELD_W-1:0] value,
    output logic               last_digit
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [FIELD_W-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    // acc*10 as shift-add; FIELD_W is sized so the full field never overflows
    assign value      = (acc << 3) + (acc << 1) + {{(FIELD_W-4){1'b0}}, digit};
    assign last_digit = digit_valid && (cnt == CNT_W'(DIGITS-1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (digit_valid) begin
            if (last_digit) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= value;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/serial_cmd_frame_parser.sv
// ASCII command-frame parser: command byte then NUM_FIELDS decimal fields,
// published atomically one clock after the final digit, with inter-byte timeout.
module serial_cmd_frame_parser
    import serial_cmd_frame_parser_pkg::*;
#(
    parameter int         NUM_FIELDS   = 3,
    parameter int         DIGITS       = 2,
    parameter int         FIELD_W      = 7,
    parameter logic [7:0] CMD_MIN      = 8'h30,
    parameter logic [7:0] CMD_MAX      = 8'h39,
    parameter int         TIMEOUT_CLKS = 50000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    output logic [7:0]                    cmd,
    output logic [NUM_FIELDS*FIELD_W-1:0] fields,
    output logic                          frame_valid,
    output logic                          frame_error,
    output logic                          busy
);

    localparam int FC_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

    logic [1:0]                    state;
    logic [FC_W-1:0]               field_cnt;
    logic [TO_W-1:0]               timer;
    logic [7:0]                    cmd_shadow;
    logic [NUM_FIELDS*FIELD_W-1:0] shadow;
    logic [NUM_FIELDS*FIELD_W-1:0] next_fields;
    logic [FIELD_W-1:0]            acc_value;
    logic                          acc_last;
    logic                          digit_ok;
    logic                          cmd_ok;
    logic                          acc_digit_valid;
    logic                          last_field;
    logic                          timer_expired;

    assign digit_ok        = is_digit(rx_data);
    assign cmd_ok          = (rx_data >= CMD_MIN) && (rx_data <= CMD_MAX);
    assign acc_digit_valid = (state == ST_FIELD) && rx_valid && digit_ok;
    assign last_field      = (field_cnt == FC_W'(NUM_FIELDS-1));
    assign timer_expired   = (timer == TO_W'(TIMEOUT_CLKS-1));

    ascii_digit_accumulator #(
        .DIGITS  (DIGITS),
        .FIELD_W (FIELD_W)
    ) u_acc (
        .clock       (clock),
        .reset       (reset),
        .clear       (state != ST_FIELD),
        .digit_valid (acc_digit_valid),
        .digit       (rx_data[3:0]),
        .value       (acc_value),
        .last_digit  (acc_last)
    );

    // Shadow image with the field currently completing merged in
    always_comb begin
        next_fields = shadow;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (field_cnt == FC_W'(i))
                next_fields[i*FIELD_W +: FIELD_W] = acc_value;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            field_cnt  <= '0;
            timer      <= '0;
            cmd_shadow <= '0;
            shadow     <= '0;
            cmd        <= '0;
            fields     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid && cmd_ok) begin
                        cmd_shadow <= rx_data;
                        field_cnt  <= '0;
                        timer      <= '0;
                        state      <= ST_FIELD;
                    end
                end
                ST_FIELD: begin
                    if (rx_valid) begin
                        timer <= '0;
                        if (!digit_ok) begin
                            state <= ST_ERR;
                        end else if (acc_last) begin
                            shadow <= next_fields;
                            if (last_field) begin
                                // publish together with the DONE pulse
                                cmd    <= cmd_shadow;
                                fields <= next_fields;
                                state  <= ST_DONE;
                            end else begin
                                field_cnt <= field_cnt + FC_W'(1);
                            end
                        end
                    end else if (timer_expired) begin
                        state <= ST_ERR;
                    end else begin
                        timer <= timer + TO_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign frame_valid = (state == ST_DONE);
    assign frame_error = (state == ST_ERR);
    assign busy        = (state == ST_FIELD) || (state == ST_DONE);

endmodule

// File: tb/tb_serial_cmd_frame_parser.sv
// Directed bench: bytes are presented as one-clock rx_valid strobes; a short
// timeout keeps the idle-expiry case brief.
module tb_serial_cmd_frame_parser;

    localparam int TO = 2000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  cmd;
    logic [20:0] fields;
    logic        frame_valid, frame_error, busy;

    logic        rx_valid3 = 1'b0;
    logic [7:0]  rx_data3 = 8'h00;
    logic [7:0]  cmd3;
    logic [19:0] fields3;
    logic        frame_valid3, frame_error3, busy3;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;

    always #5 clock = ~clock;

    serial_cmd_frame_parser #(.TIMEOUT_CLKS(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .cmd         (cmd),
        .fields      (fields),
        .frame_valid (frame_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    serial_cmd_frame_parser #(.NUM_FIELDS(2), .DIGITS(3), .FIELD_W(10), .TIMEOUT_CLKS(TO)) dut3 (
        .clock       (clock),
        .reset       (reset),
        .rx_valid    (rx_valid3),
        .rx_data     (rx_data3),
        .cmd         (cmd3),
        .fields      (fields3),
        .frame_valid (frame_valid3),
        .frame_error (frame_error3),
        .busy        (busy3)
    );

    always @(posedge clock) begin
        if (frame_valid) fv_cnt++;
        if (frame_error) fe_cnt++;
        if (frame_valid && frame_error) both_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clock);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        put(b);
        idle(2);
    endtask

    task automatic put3(input logic [7:0] b);
        rx_valid3 = 1'b1;
        rx_data3  = b;
        @(posedge clock);
        #1 rx_valid3 = 1'b0;
        idle(2);
    endtask

    initial begin
        // reset state
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
        chk("rst_cmd", cmd, 0);
        chk("rst_fields", fields, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_fe", frame_error, 0);
        chk("rst_busy", busy, 0);

        // 1: basic frame 0 | 10 20 15
        put(8'h30);
        chk("t1_busy_after_cmd", busy, 1);
        idle(2);
        send(8'h31); send(8'h30); send(8'h32); send(8'h30); send(8'h31);
        chk("t1_no_fv_early", fv_cnt, 0);
        put(8'h35);
        chk("t1_fv", frame_valid, 1);
        chk("t1_cmd", cmd, 8'h30);
        chk("t1_fields", fields, {7'd15, 7'd20, 7'd10});
        idle(1);
        chk("t1_fv_one_clk", frame_valid, 0);
        chk("t1_busy_idle", busy, 0);
        chk("t1_fv_cnt", fv_cnt, 1);
        chk("t1_fe_cnt", fe_cnt, 0);

        // 2: non-digit aborts, outputs held, next frame accepted
        send(8'h30); send(8'h31);
        put(8'h41);
        chk("t2_fe", frame_error, 1);
        chk("t2_fv_low", frame_valid, 0);
        chk("t2_busy_err", busy, 0);
        chk("t2_fields_held", fields, {7'd15, 7'd20, 7'd10});
        idle(2);
        chk("t2_fe_cnt", fe_cnt, 1);
        send(8'h32); send(8'h30); send(8'h35); send(8'h30); send(8'h36); send(8'h30);
        put(8'h37);
        chk("t2_cmd", cmd, 8'h32);
        chk("t2_fields", fields, {7'd7, 7'd6, 7'd5});
        idle(2);

        // 3: timeout exactly TO clocks after the last byte
        put(8'h30);
        put(8'h31);
        idle(TO - 1);
        chk("t3_no_fe_before", frame_error, 0);
        chk("t3_busy_before", busy, 1);
        idle(1);
        chk("t3_fe_at_timeout", frame_error, 1);
        chk("t3_busy_fall", busy, 0);
        idle(1);
        chk("t3_fe_one_clk", frame_error, 0);
        idle(2);
        // a byte on the expiry cycle wins over the timeout
        put(8'h30);
        put(8'h31);
        idle(TO - 1);
        put(8'h32);
        chk("t3_byte_wins_fe", frame_error, 0);
        chk("t3_byte_wins_busy", busy, 1);
        idle(2);
        send(8'h30); send(8'h33); send(8'h30);
        put(8'h34);
        chk("t3_fields", fields, {7'd4, 7'd3, 7'd12});
        idle(2);

        // 4: leading noise ignored
        send(8'h0A);
        chk("t4_noise_busy", busy, 0);
        send(8'h0D);
        send(8'h30); send(8'h39); send(8'h39); send(8'h30); send(8'h30); send(8'h30);
        put(8'h31);
        chk("t4_fv", frame_valid, 1);
        chk("t4_fields", fields, {7'd1, 7'd0, 7'd99});
        idle(2);
        chk("t4_fe_cnt", fe_cnt, 2);
        chk("t4_fv_cnt", fv_cnt, 4);

        // 5: reset mid-frame
        send(8'h30); send(8'h31);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("t5_rst_cmd", cmd, 0);
        chk("t5_rst_fields", fields, 0);
        chk("t5_rst_busy", busy, 0);
        send(8'h39); send(8'h31); send(8'h31); send(8'h32); send(8'h32); send(8'h33);
        put(8'h33);
        chk("t5_cmd", cmd, 8'h39);
        chk("t5_fields", fields, {7'd33, 7'd22, 7'd11});
        idle(2);

        // 6: three-digit, two-field instance
        put3(8'h35); put3(8'h39); put3(8'h39); put3(8'h39); put3(8'h30); put3(8'h30);
        rx_valid3 = 1'b1;
        rx_data3  = 8'h37;
        @(posedge clock);
        #1 rx_valid3 = 1'b0;
        chk("t6_fv", frame_valid3, 1);
        chk("t6_cmd", cmd3, 8'h35);
        chk("t6_fields", fields3, {10'd7, 10'd999});
        chk("t6_fe", frame_error3, 0);
        idle(2);

        chk("never_both", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
